// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: op encodings, FSM states,
// parameter legality checks and operand signedness decode.
// No logic of its own; imported by the multiplier top and its step datapath.
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operand width must be even and within 8..64.
  function automatic bit width_legal(int w);
    return (w >= 8) && (w <= 64) && ((w % 2) == 0);
  endfunction

  // Bits retired per CALC cycle must be 1, 2 or 4 and divide the width.
  function automatic bit bpc_legal(int w, int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((w % bpc) == 0);
  endfunction

  // rs1 is signed for MULH and MULHSU.
  function automatic bit a_is_signed(logic [1:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // rs2 is signed for MULH only.
  function automatic bit b_is_signed(logic [1:0] op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: adds the partial products of |a| selected by the
// current multiplier bits into the accumulator. Purely combinational.
// No flow control; the caller sequences iterations.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int BITS_PER_CYC = 1,
  parameter int CNT_W        = 5
) (
  input  logic [2*WIDTH-1:0]    acc_i,
  input  logic [WIDTH-1:0]      a_abs_i,
  input  logic [BITS_PER_CYC-1:0] b_bits_i,
  input  logic [CNT_W-1:0]      iter_i,
  output logic [2*WIDTH-1:0]    acc_next_o
);

  // Bit k of this group carries weight iter*BITS_PER_CYC + k.
  always_comb begin
    acc_next_o = acc_i;
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      if (b_bits_i[k]) begin
        acc_next_o = acc_next_o +
                     ({{WIDTH{1'b0}}, a_abs_i} << (int'(iter_i) * BITS_PER_CYC + k));
      end
    end
  end

endmodule

// File: rtl/seq_multiply_unit.sv
// Sequential RISC-V M multiplier (MUL/MULH/MULHSU/MULHU) on magnitudes with a final sign fix.
// Latency: WIDTH/BITS_PER_CYC + 2 cycles from accept edge to first edge sampling out_valid.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module seq_multiply_unit
  import mul_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int STEPS = WIDTH / BITS_PER_CYC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(STEPS - 1);

  if (!width_legal(WIDTH) || !bpc_legal(WIDTH, BITS_PER_CYC)) begin : g_bad_params
    $error("seq_multiply_unit: illegal WIDTH/BITS_PER_CYC combination");
  end

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_abs_q, a_abs_d;
  logic [WIDTH-1:0]     b_abs_q, b_abs_d;
  logic                 neg_q, neg_d;
  logic [CNT_W-1:0]     iter_q, iter_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 a_neg, b_neg;

  assign a_neg = a_is_signed(op) && a[WIDTH-1];
  assign b_neg = b_is_signed(op) && b[WIDTH-1];

  // The multiplier register shifts right each step, so the low bits are always
  // the group belonging to the current iteration.
  mul_step #(
    .WIDTH        (WIDTH),
    .BITS_PER_CYC (BITS_PER_CYC),
    .CNT_W        (CNT_W)
  ) u_step (
    .acc_i      (acc_q),
    .a_abs_i    (a_abs_q),
    .b_bits_i   (b_abs_q[BITS_PER_CYC-1:0]),
    .iter_i     (iter_q),
    .acc_next_o (step_acc)
  );

  // Next-state and datapath updates for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_abs_d = a_abs_q;
    b_abs_d = b_abs_q;
    neg_d   = neg_q;
    iter_d  = iter_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          // Negating the most-negative value yields the correct unsigned magnitude.
          a_abs_d = a_neg ? (~a + 1'b1) : a;
          b_abs_d = b_neg ? (~b + 1'b1) : b;
          neg_d   = a_neg ^ b_neg;
          iter_d  = '0;
          acc_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d   = step_acc;
        b_abs_d = b_abs_q >> BITS_PER_CYC;
        iter_d  = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (neg_q) begin
          acc_d = ~acc_q + 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      a_abs_q <= '0;
      b_abs_q <= '0;
      neg_q   <= 1'b0;
      iter_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_abs_q <= a_abs_d;
      b_abs_q <= b_abs_d;
      neg_q   <= neg_d;
      iter_q  <= iter_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign product   = out_valid ? acc_q : '0;
  assign result    = !out_valid         ? '0 :
                     (op_q == OP_MUL)   ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_multiply_unit.sv
// Scoreboard bench: drivers push expected results, monitors pop on each handoff.
// Instance A uses the defaults (32-bit, 1 bit/cycle); instance B is 16-bit, 4 bits/cycle.
// Inputs change on the falling edge; monitors sample 1 time unit after it.
module tb_seq_multiply_unit;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        da_in_valid, da_in_ready, da_out_valid, da_out_ready, da_busy;
  logic [1:0]  da_op;
  logic [31:0] da_opa, da_opb, da_result;
  logic [63:0] da_product;

  logic        db_in_valid, db_in_ready, db_out_valid, db_out_ready, db_busy;
  logic [1:0]  db_op;
  logic [15:0] db_opa, db_opb, db_result;
  logic [31:0] db_product;

  seq_multiply_unit u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(da_in_valid), .in_ready(da_in_ready),
    .op(da_op), .a(da_opa), .b(da_opb), .out_valid(da_out_valid),
    .out_ready(da_out_ready), .result(da_result), .product(da_product), .busy(da_busy)
  );

  seq_multiply_unit #(.WIDTH(16), .BITS_PER_CYC(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(db_in_valid), .in_ready(db_in_ready),
    .op(db_op), .a(db_opa), .b(db_opb), .out_valid(db_out_valid),
    .out_ready(db_out_ready), .result(db_result), .product(db_product), .busy(db_busy)
  );

  int compared   = 0;
  int mismatched = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] p; logic [31:0] r; int unsigned t; } exp_a_t;
  typedef struct { logic [31:0] p; logic [15:0] r; int unsigned t; } exp_b_t;
  exp_a_t qa[$];
  exp_b_t qb[$];
  bit seen_a = 1'b0;
  bit seen_b = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string msg);
    compared++;
    mismatched++;
    $display("FAIL %s", msg);
  endtask

  // Independent reference for the 16-bit instance using native 64-bit multiply.
  function automatic logic [31:0] ref16(input logic [1:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    longint sx, sy, p;
    sx = (o == OP_MULH || o == OP_MULHSU) ? longint'($signed(x)) : longint'(x);
    sy = (o == OP_MULH) ? longint'($signed(y)) : longint'(y);
    p  = sx * sy;
    return p[31:0];
  endfunction

  // Monitor A: latency on first sight, value checks every valid cycle, pop on handoff.
  always @(negedge clk) begin
    #1;
    if (da_out_valid) begin
      if (qa.size() == 0) begin
        fail_now("a_unexpected: out_valid=1 with no result pending, required 0");
      end else begin
        if (!seen_a) begin
          seen_a = 1'b1;
          check("a_latency", 64'(cyc - qa[0].t), 64'd34);
        end
        check("a_result", 64'(da_result), 64'(qa[0].r));
        check("a_product", da_product, qa[0].p);
        if (da_out_ready) begin
          void'(qa.pop_front());
          seen_a = 1'b0;
        end
      end
    end else if (rst_n) begin
      check("a_gated_zero", 64'(|{da_result, da_product}), 64'd0);
    end
  end

  // Monitor B: same scheme for the 16-bit, 4-bit-per-cycle instance.
  always @(negedge clk) begin
    #1;
    if (db_out_valid) begin
      if (qb.size() == 0) begin
        fail_now("b_unexpected: out_valid=1 with no result pending, required 0");
      end else begin
        if (!seen_b) begin
          seen_b = 1'b1;
          check("b_latency", 64'(cyc - qb[0].t), 64'd6);
        end
        check("b_result", 64'(db_result), 64'(qb[0].r));
        check("b_product", 64'(db_product), 64'(qb[0].p));
        if (db_out_ready) begin
          void'(qb.pop_front());
          seen_b = 1'b0;
        end
      end
    end
  end

  task automatic issue_a(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] ep, input logic [31:0] er, input bit expect_out);
    int n;
    n = 0;
    while (!da_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!da_in_ready) begin
      fail_now("a_accept_timeout: in_ready=0, required 1");
    end else begin
      da_in_valid = 1'b1;
      da_op = o;
      da_opa = x;
      da_opb = y;
      if (expect_out) qa.push_back('{p: ep, r: er, t: cyc});
      @(negedge clk);
      da_in_valid = 1'b0;
    end
  endtask

  task automatic issue_b(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] ep, input logic [15:0] er);
    int n;
    n = 0;
    while (!db_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!db_in_ready) begin
      fail_now("b_accept_timeout: in_ready=0, required 1");
    end else begin
      db_in_valid = 1'b1;
      db_op = o;
      db_opa = x;
      db_opb = y;
      qb.push_back('{p: ep, r: er, t: cyc});
      @(negedge clk);
      db_in_valid = 1'b0;
    end
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0) fail_now("a_drain_timeout: results still pending, required none");
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while (qb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (qb.size() != 0) fail_now("b_drain_timeout: results still pending, required none");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [15:0] rx, ry;
    logic [31:0] rp;
    int n;

    rst_n = 1'b1;
    da_in_valid = 1'b0; da_op = OP_MUL; da_opa = '0; da_opb = '0; da_out_ready = 1'b1;
    db_in_valid = 1'b0; db_op = OP_MUL; db_opa = '0; db_opb = '0; db_out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(da_in_ready), 64'd1);
    check("rst_out_valid", 64'(da_out_valid), 64'd0);
    check("rst_busy", 64'(da_busy), 64'd0);
    check("rst_outputs_zero", 64'(|{da_result, da_product}), 64'd0);
    check("rst_b_in_ready", 64'(db_in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on the default instance.
    issue_a(OP_MUL,    32'd7,         32'd6,         64'd42,                 32'd42,        1'b1);
    issue_a(OP_MULH,   32'hFFFFFFFF,  32'h00000002,  64'hFFFFFFFF_FFFFFFFE,  32'hFFFFFFFF,  1'b1);
    issue_a(OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFF_00000001,  32'hFFFFFFFF,  1'b1);
    issue_a(OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001,  32'hFFFFFFFE,  1'b1);
    issue_a(OP_MULH,   32'h80000000,  32'h80000000,  64'h40000000_00000000,  32'h40000000,  1'b1);
    issue_a(OP_MUL,    32'h00000000,  32'h12345678,  64'd0,                  32'd0,         1'b1);
    issue_a(OP_MULH,   32'hFFFFFFFD,  32'h00000005,  64'hFFFFFFFF_FFFFFFF1,  32'hFFFFFFFF,  1'b1);
    issue_a(OP_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001,  32'h00000001,  1'b1);
    issue_a(OP_MULHU,  32'h00010000,  32'h00010000,  64'h00000001_00000000,  32'h00000001,  1'b1);
    issue_a(OP_MULHSU, 32'h80000000,  32'h00000002,  64'hFFFFFFFF_00000000,  32'hFFFFFFFF,  1'b1);
    issue_a(OP_MULH,   32'h12345678,  32'hFFFFFFFF,  64'hFFFFFFFF_EDCBA988,  32'hFFFFFFFF,  1'b1);
    drain_a();

    // Hold the result in DONE for 10 cycles while a competing request is offered.
    da_out_ready = 1'b0;
    issue_a(OP_MUL, 32'd100, 32'd3, 64'd300, 32'd300, 1'b1);
    n = 0;
    while (!da_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!da_out_valid) fail_now("hold_wait_timeout: out_valid=0, required 1");
    for (int i = 0; i < 10; i++) begin
      check("hold_in_ready", 64'(da_in_ready), 64'd0);
      check("hold_busy", 64'(da_busy), 64'd1);
      da_in_valid = 1'b1;
      da_op = OP_MULHU;
      da_opa = 32'hDEADBEEF;
      da_opb = 32'h0BADF00D;
      @(negedge clk);
    end
    da_in_valid = 1'b0;
    da_out_ready = 1'b1;
    check("handoff_in_ready", 64'(da_in_ready), 64'd0);
    @(negedge clk);
    check("after_handoff_in_ready", 64'(da_in_ready), 64'd1);
    drain_a();

    // Reset mid-CALC discards the operation; the next request completes normally.
    issue_a(OP_MUL, 32'd5, 32'd5, 64'd25, 32'd25, 1'b0);
    repeat (14) @(negedge clk);
    check("calc_busy_before_reset", 64'(da_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(da_in_ready), 64'd1);
    check("midrst_out_valid", 64'(da_out_valid), 64'd0);
    check("midrst_busy", 64'(da_busy), 64'd0);
    check("midrst_outputs_zero", 64'(|{da_result, da_product}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_in_ready", 64'(da_in_ready), 64'd1);
    issue_a(OP_MUL, 32'd9, 32'd9, 64'd81, 32'd81, 1'b1);
    drain_a();

    // 16-bit, 4 bits per cycle: directed corner then reference-checked random ops.
    issue_b(OP_MULH, 16'h8000, 16'h8000, 32'h40000000, 16'h4000);
    for (int i = 0; i < 1000; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i % 7 == 0) rx = 16'h8000;
      if (i % 11 == 0) ry = 16'hFFFF;
      if (i % 13 == 0) ry = 16'h0000;
      rp = ref16(ro, rx, ry);
      issue_b(ro, rx, ry, rp, (ro == OP_MUL) ? rp[15:0] : rp[31:16]);
    end
    drain_b();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_multiply_unit.md
SEQ_MULTIPLY_UNIT -- requirements
Module: seq_multiply_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32; operand width; legal values 8..64, even.
REQ-002 SHALL have parameter BITS_PER_CYC, default 1; multiplier bits retired per CALC cycle; legal values 1, 2, 4; must divide WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RISC-V M semantics).
REQ-008 SHALL have port a  input  WIDTH  multiplicand (rs1).
REQ-009 SHALL have port b  input  WIDTH  multiplier (rs2).
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  selected half: low half for MUL, high half otherwise.
REQ-013 SHALL have port product  output  2*WIDTH  full signed or unsigned product per op.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-016 SHALL assert in_ready only in IDLE; a request is accepted on an edge where in_valid and in_ready are both high.
REQ-017 On accept, SHALL latch op, |a| and |b|, and the result sign; a is signed for op 01/10, b is signed for op 01 only; then SHALL move to CALC.
REQ-018 CALC SHALL last exactly WIDTH/BITS_PER_CYC cycles, each adding BITS_PER_CYC shifted partial products of |a| into a 2*WIDTH accumulator (shift-add, LSB first).
REQ-019 FIX SHALL last one cycle and SHALL two's-complement negate the accumulator when the result sign is 1; then SHALL move to DONE.
REQ-020 Latency from accept edge to first edge with out_valid high SHALL be WIDTH/BITS_PER_CYC + 2 cycles (34 for the defaults).
REQ-021 DONE SHALL hold out_valid, result and product stable until out_ready is high, then SHALL return to IDLE on that edge.
REQ-022 A new request SHALL NOT be accepted in the same cycle as a result handoff; in_ready rises the cycle after.
REQ-023 The most-negative operand SHALL be handled exactly, e.g. MULH(0x80000000, 0x80000000) = 0x40000000.
REQ-024 A zero operand SHALL NOT shorten latency; the cycle count is fixed.
REQ-025 in_valid, op, a and b SHALL be ignored outside IDLE.
REQ-026 out_valid SHALL be high only in DONE; result and product SHALL read 0 when out_valid is low.

Reset
REQ-027 Asserting rst_n low SHALL immediately force IDLE, with in_ready=1, out_valid=0, busy=0, and result, product and accumulator at 0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL discard the operation; no result is produced after release.
REQ-029 After rst_n deasserts, the first request SHALL be acceptable on the first rising edge.

Structure
REQ-030 Package mul_pkg SHALL hold the op encoding constants, the state enum, and the legality checks for WIDTH and BITS_PER_CYC.
REQ-031 Sub-module mul_step SHALL compute one CALC iteration combinationally: acc_next = acc + sum over k of (|a| AND b_bit[k]) shifted by (iteration*BITS_PER_CYC + k).
REQ-032 Illegal parameter combinations SHALL fail elaboration.

Verification
REQ-033 Defaults, MUL a=7, b=6, out_ready=1: out_valid on cycle 34 after accept; result=42; product=42.
REQ-034 MULH a=0xFFFFFFFF (-1), b=0x00000002: product=0xFFFFFFFF_FFFFFFFE; result=0xFFFFFFFF.
REQ-035 MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF: result=0xFFFFFFFF; MULHU with the same operands: result=0xFFFFFFFE.
REQ-036 out_ready held low for 10 cycles in DONE: out_valid and result stay stable, in_ready stays 0, and a new in_valid is ignored.
REQ-037 rst_n pulsed low at CALC cycle 15: in_ready=1 and out_valid=0 immediately; no out_valid afterwards; the next request completes correctly.
REQ-038 BITS_PER_CYC=4, WIDTH=16, MULH a=0x8000, b=0x8000: latency 6 cycles; result=0x4000; 1000 random ops match a reference model.
